// File: rtl/instr_mem_loader.sv
// Instruction memory loader: takes a 16-bit big-endian word count and then big-endian
// 32-bit words from a byte stream, and writes them to consecutive word-aligned addresses.
module instr_mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        Clk,
    input  logic        R,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_in_ready, r_mem_we, r_cpu_hold, r_done, r_error;
    logic [31:0] r_mem_addr, r_mem_wdata;
    logic [7:0]  r_cnt_hi;
    logic [15:0] r_remain;
    logic [16:0] r_widx;
    logic [1:0]  r_bidx;
    logic        w_accept;
    logic [15:0] w_count;

    assign w_accept = in_valid && r_in_ready;
    assign w_count  = {r_cnt_hi, in_data};

    always_ff @(posedge Clk) begin
        if (!R) r_state <= S_IDLE;
        else    r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_HDR_HI;
            S_HDR_HI: if (w_accept) w_state_nxt = S_HDR_LO;
            S_HDR_LO: if (w_accept) w_state_nxt = (w_count == 16'd0) ? S_DONE : S_DATA;
            S_DATA:   if (w_accept && r_bidx == 2'd3) w_state_nxt = S_WRITE;
            S_WRITE:  w_state_nxt = (r_remain == 16'd1) ? S_DONE : S_DATA;
            S_DONE:   if (start) w_state_nxt = S_HDR_HI;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge Clk) begin
        if (!R) begin
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cnt_hi    <= '0;
            r_remain    <= '0;
            r_widx      <= '0;
            r_bidx      <= '0;
        end else begin
            r_in_ready <= (w_state_nxt == S_HDR_HI) || (w_state_nxt == S_HDR_LO) ||
                          (w_state_nxt == S_DATA);
            r_done     <= (w_state_nxt == S_DONE);
            r_cpu_hold <= (w_state_nxt != S_DONE);
            // Words past capacity are still consumed, just never strobed.
            r_mem_we   <= (w_state_nxt == S_WRITE) && (r_widx < CAP);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_mem_addr <= '0;
                        r_bidx     <= '0;
                        r_widx     <= '0;
                        r_error    <= 1'b0;
                    end
                end
                S_HDR_HI: if (w_accept) r_cnt_hi <= in_data;
                S_HDR_LO: begin
                    if (w_accept) begin
                        r_remain <= w_count;
                        if ({1'b0, w_count} > CAP) r_error <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_mem_wdata[{~r_bidx, 3'b000} +: 8] <= in_data;
                        r_bidx <= r_bidx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_mem_addr <= r_mem_addr + 32'd4;
                    r_remain   <= r_remain - 16'd1;
                    r_widx     <= r_widx + 17'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;

endmodule
